fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the control unit.
- Takes the control unit's one-cycle start-fetch pulse and the current PC, and runs one read transaction on the memory bus.
- Latches the returned word into the instruction register and returns a one-cycle fetch-done strobe, which drives the control unit's bus data-valid input in its FETCH state.
- Issues the first fetch by itself after reset, because the control unit comes out of reset already in FETCH.

---
 rtl/fetch_pkg.sv | 21 ++
 rtl/fetch_timeout_ctr.sv | 44 ++++
 rtl/fetch_unit.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch stage.
//   - FSM state encoding (BOOT/IDLE/REQ/DROP)
//   - default address and data widths
//   - PC misalignment mask and a helper that tests the low PC bits
package fetch_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_DROP = 2'd3;

    localparam logic [1:0] MISALIGN_MASK = 2'b11;

    function automatic logic pc_misaligned(input logic [1:0] pc_lsb);
        return (pc_lsb & MISALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// fetch_timeout_ctr: cycle counter bounding how long a fetch waits for a bus ack.
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_clr      hold the count at zero (fetch not outstanding)
//   i_en       count this cycle (fetch outstanding)
//   o_expired  high in the LIMIT-th counted cycle
// Only instantiated when FETCH_TIMEOUT_EN is defined.
module fetch_timeout_ctr #(
    parameter int LIMIT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The count holds the number of cycles already spent waiting, so the
    // LIMIT-th waiting cycle is the one where it equals LIMIT-1.
    assign o_expired = i_en && (cnt_q == CW'(LIMIT - 1));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the control unit.
// Runs one bus read per start pulse (plus one automatic fetch after reset),
// latches the returned word into the instruction register and strobes
// o_fetch_dv for one cycle. Misaligned PCs fault without touching the bus.
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_start_fetch, i_pc  fetch request pulse and address
//   i_flush              discard the fetch in flight
//   o_bus_rd, o_bus_addr bus read request and address
//   i_bus_ack, i_bus_rdata bus completion and read data
//   o_instr              instruction register
//   o_fetch_dv           one-cycle completion strobe
//   o_fetch_fault        one-cycle fault strobe (with o_fetch_dv)
//   o_busy               FSM not in IDLE
// Optional feature: define FETCH_TIMEOUT_EN to abandon a read after
// FETCH_TIMEOUT cycles without ack.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int FETCH_TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start_fetch,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_flush,
    output logic              o_bus_rd,
    output logic [ADDR_W-1:0] o_bus_addr,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_fetch_dv,
    output logic              o_fetch_fault,
    output logic              o_busy
);

    logic [1:0]        state_q, state_d;
    logic              bus_rd_q, bus_rd_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic              fetch_dv_q, fetch_dv_d;
    logic              fetch_fault_q, fetch_fault_d;
    logic              timeout_hit;
    logic              waiting;

    assign waiting = (state_q == ST_REQ) || (state_q == ST_DROP);

`ifdef FETCH_TIMEOUT_EN
    fetch_timeout_ctr #(
        .LIMIT(FETCH_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clr     (!waiting),
        .i_en      (waiting),
        .o_expired (timeout_hit)
    );
`else
    localparam int unused_timeout = FETCH_TIMEOUT;
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        bus_rd_d      = bus_rd_q;
        bus_addr_d    = bus_addr_q;
        instr_d       = instr_q;
        fetch_dv_d    = 1'b0;
        fetch_fault_d = 1'b0;

        case (state_q)
            // The control unit leaves reset in FETCH, so fetch without a start pulse.
            ST_BOOT: begin
                if (pc_misaligned(i_pc[1:0])) begin
                    fetch_dv_d    = 1'b1;
                    fetch_fault_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    bus_addr_d = i_pc;
                    bus_rd_d   = 1'b1;
                    state_d    = ST_REQ;
                end
            end

            ST_IDLE: begin
                if (i_start_fetch && !i_flush) begin
                    if (pc_misaligned(i_pc[1:0])) begin
                        // Suppressed while a strobe is already out so the
                        // strobe can never last two cycles.
                        if (!fetch_dv_q) begin
                            fetch_dv_d    = 1'b1;
                            fetch_fault_d = 1'b1;
                        end
                    end else begin
                        bus_addr_d = i_pc;
                        bus_rd_d   = 1'b1;
                        state_d    = ST_REQ;
                    end
                end
            end

            ST_REQ: begin
                if (i_bus_ack) begin
                    bus_rd_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (!i_flush) begin
                        instr_d    = i_bus_rdata;
                        fetch_dv_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    // A flush on the expiry cycle turns the fault into a silent drop.
                    bus_rd_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (!i_flush) begin
                        fetch_dv_d    = 1'b1;
                        fetch_fault_d = 1'b1;
                    end
                end else if (i_flush) begin
                    // The bus read cannot be aborted; keep requesting and discard the data.
                    state_d = ST_DROP;
                end
            end

            ST_DROP: begin
                if (i_bus_ack || timeout_hit) begin
                    bus_rd_d = 1'b0;
                    state_d  = ST_IDLE;
                end
            end

            default: begin
                bus_rd_d = 1'b0;
                state_d  = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= ST_BOOT;
            bus_rd_q      <= 1'b0;
            bus_addr_q    <= '0;
            instr_q       <= '0;
            fetch_dv_q    <= 1'b0;
            fetch_fault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_rd_q      <= bus_rd_d;
            bus_addr_q    <= bus_addr_d;
            instr_q       <= instr_d;
            fetch_dv_q    <= fetch_dv_d;
            fetch_fault_q <= fetch_fault_d;
        end
    end

    assign o_bus_rd      = bus_rd_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_instr       = instr_q;
    assign o_fetch_dv    = fetch_dv_q;
    assign o_fetch_fault = fetch_fault_q;
    assign o_busy        = (state_q != ST_IDLE);

endmodule
